// File: rtl/sram_phys_responder.sv
// Memory-side responder for physically addressed CPU requests: word-organised RAM,
// fixed response latency, one outstanding transaction, flags misaligned/out-of-range.
module sram_phys_responder #(
  parameter int unsigned MEM_AW  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  if (LATENCY > 15) begin : gen_latency_check
    $error("sram_phys_responder: LATENCY must be in 0..15");
  end

  localparam int unsigned Words = 1 << MEM_AW;
  localparam logic [3:0]  LatCnt = LATENCY[3:0];

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem [Words];

  logic        handshake;
  logic        src_wr;
  logic [1:0]  src_size;
  logic [31:0] src_addr;
  logic        src_err;
  logic [3:0]  be;

  function automatic logic req_err(input logic [1:0] sz, input logic [31:0] a);
    logic mis;
    unique case (sz)
      2'd0:    mis = 1'b0;
      2'd1:    mis = a[0];
      2'd2:    mis = |a[1:0];
      default: mis = 1'b1;
    endcase
    return mis | (|(a >> (MEM_AW + 2)));
  endfunction

  assign handshake = req & addr_ok;

  // With LATENCY = 0 the response is set up on the accept edge itself, so look at the
  // live inputs while idle and at the captured copy otherwise.
  always_comb begin
    if (state_q == StIdle) begin
      src_wr   = wr;
      src_size = size;
      src_addr = addr;
    end else begin
      src_wr   = wr_q;
      src_size = size_q;
      src_addr = addr_q;
    end
  end

  assign src_err = req_err(src_size, src_addr);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          if (LATENCY == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = LatCnt;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    addr_ok = (state_q == StIdle);
    data_ok = (state_q == StResp);
    rdata   = rdata_q;
    err     = err_q;
  end

  // Request capture and response data; rdata/err are zero outside the response cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      if (handshake) begin
        wr_q    <= wr;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state_d == StResp) begin
        err_q   <= src_err;
        rdata_q <= (src_wr || src_err) ? 32'd0 : mem[src_addr[MEM_AW+1:2]];
      end else begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  always_comb begin
    unique case (size_q)
      2'd0:    be = 4'b0001 << addr_q[1:0];
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Writes commit at the end of the response cycle; an async reset leaves StResp first.
  always_ff @(posedge clk) begin
    if (state_q == StResp && wr_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr_q[MEM_AW+1:2]][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_phys_responder.sv
// Directed bench for sram_phys_responder: one DUT at LATENCY=2, one at LATENCY=0.
module tb_sram_phys_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        sel = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;

  logic        req2, req0;
  logic        addr_ok2, data_ok2, err2;
  logic        addr_ok0, data_ok0, err0;
  logic [31:0] rdata2, rdata0;
  logic        dok, er;
  logic [31:0] rdat;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign req2 = req & ~sel;
  assign req0 = req & sel;
  assign dok  = sel ? data_ok0 : data_ok2;
  assign er   = sel ? err0 : err2;
  assign rdat = sel ? rdata0 : rdata2;

  sram_phys_responder #(.MEM_AW(10), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok2), .data_ok(data_ok2), .rdata(rdata2), .err(err2)
  );

  sram_phys_responder #(.MEM_AW(10), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok0), .data_ok(data_ok0), .rdata(rdata0), .err(err0)
  );

  // One transaction on the selected DUT; lat = cycles from handshake to data_ok (0 = none).
  task automatic txn(input logic w, input logic [1:0] s, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output logic e,
                     output int lat);
    @(negedge clk);
    req = 1'b1; wr = w; size = s; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0;
    lat = 0; rd = 32'd0; e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (dok) begin
        lat = k; rd = rdat; e = er;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (data_ok2 !== 1'b0) $display("FAIL rst_data_ok: got %b want 0", data_ok2); else passed++;
    total++; if (rdata2 !== 32'd0) $display("FAIL rst_rdata: got %h want 0", rdata2); else passed++;
    total++; if (err2 !== 1'b0) $display("FAIL rst_err: got %b want 0", err2); else passed++;
    reset = 1'b0;
    #1;
    total++; if (addr_ok2 !== 1'b1) $display("FAIL rst_addr_ok2: got %b want 1", addr_ok2); else passed++;
    total++; if (addr_ok0 !== 1'b1) $display("FAIL rst_addr_ok0: got %b want 1", addr_ok0); else passed++;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic e; int lat;
    txn(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, rd, e, lat);
    total++; if (lat !== 3) $display("FAIL wr_latency: got %0d want 3", lat); else passed++;
    total++; if (e !== 1'b0) $display("FAIL wr_err: got %b want 0", e); else passed++;
    total++; if (rd !== 32'd0) $display("FAIL wr_rdata: got %h want 0", rd); else passed++;
    txn(1'b0, 2'd2, 32'h10, 32'h0, rd, e, lat);
    total++; if (lat !== 3) $display("FAIL rd_latency: got %0d want 3", lat); else passed++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", rd); else passed++;
    total++; if (e !== 1'b0) $display("FAIL rd_err: got %b want 0", e); else passed++;
    @(negedge clk);
    total++; if (data_ok2 !== 1'b0) $display("FAIL data_ok_width: got %b want 0", data_ok2); else passed++;
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic e; int lat;
    txn(1'b1, 2'd0, 32'h11, 32'h0000AA00, rd, e, lat);
    total++; if (e !== 1'b0) $display("FAIL byte_wr_err: got %b want 0", e); else passed++;
    txn(1'b0, 2'd2, 32'h10, 32'h0, rd, e, lat);
    total++; if (rd !== 32'hDEADAAEF) $display("FAIL byte_rd: got %h want deadaaef", rd); else passed++;
    txn(1'b1, 2'd1, 32'h12, 32'h12340000, rd, e, lat);
    total++; if (e !== 1'b0) $display("FAIL half_wr_err: got %b want 0", e); else passed++;
    txn(1'b0, 2'd2, 32'h10, 32'h0, rd, e, lat);
    total++; if (rd !== 32'h1234AAEF) $display("FAIL half_rd: got %h want 1234aaef", rd); else passed++;
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic e; int lat;
    txn(1'b1, 2'd1, 32'h13, 32'hFFFFFFFF, rd, e, lat);
    total++; if (e !== 1'b1) $display("FAIL mis_half_wr_err: got %b want 1", e); else passed++;
    total++; if (lat !== 3) $display("FAIL mis_half_wr_lat: got %0d want 3", lat); else passed++;
    txn(1'b0, 2'd2, 32'h12, 32'h0, rd, e, lat);
    total++; if (e !== 1'b1) $display("FAIL mis_word_rd_err: got %b want 1", e); else passed++;
    total++; if (rd !== 32'd0) $display("FAIL mis_word_rd_data: got %h want 0", rd); else passed++;
    txn(1'b0, 2'd3, 32'h10, 32'h0, rd, e, lat);
    total++; if (e !== 1'b1) $display("FAIL size3_err: got %b want 1", e); else passed++;
    total++; if (rd !== 32'd0) $display("FAIL size3_data: got %h want 0", rd); else passed++;
    txn(1'b0, 2'd2, 32'h10, 32'h0, rd, e, lat);
    total++; if (rd !== 32'h1234AAEF) $display("FAIL mis_keep: got %h want 1234aaef", rd); else passed++;
    total++; if (e !== 1'b0) $display("FAIL mis_keep_err: got %b want 0", e); else passed++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic e; int lat;
    txn(1'b1, 2'd2, 32'h0, 32'hCAFEF00D, rd, e, lat);
    txn(1'b0, 2'd2, 32'h1000, 32'h0, rd, e, lat);
    total++; if (e !== 1'b1) $display("FAIL oor_rd_err: got %b want 1", e); else passed++;
    total++; if (rd !== 32'd0) $display("FAIL oor_rd_data: got %h want 0", rd); else passed++;
    txn(1'b1, 2'd2, 32'h1FC00000, 32'h11111111, rd, e, lat);
    total++; if (e !== 1'b1) $display("FAIL oor_wr_err: got %b want 1", e); else passed++;
    txn(1'b0, 2'd2, 32'h0, 32'h0, rd, e, lat);
    total++; if (rd !== 32'hCAFEF00D) $display("FAIL oor_keep: got %h want cafef00d", rd); else passed++;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic e; int lat; int seen;
    txn(1'b1, 2'd2, 32'h20, 32'h0BADF00D, rd, e, lat);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req = 1'b0; wr = 1'b0;
    @(negedge clk);
    total++; if (addr_ok2 !== 1'b0) $display("FAIL abort_in_wait: got %b want 0", addr_ok2); else passed++;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (addr_ok2 !== 1'b1) $display("FAIL abort_addr_ok: got %b want 1", addr_ok2); else passed++;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (data_ok2) seen++;
    end
    total++; if (seen !== 0) $display("FAIL abort_no_data_ok: got %0d pulses want 0", seen); else passed++;
    txn(1'b0, 2'd2, 32'h20, 32'h0, rd, e, lat);
    total++; if (rd !== 32'h0BADF00D) $display("FAIL abort_keep: got %h want 0badf00d", rd); else passed++;
  endtask

  task automatic test_latency_zero();
    logic [31:0] rd; logic e; int lat;
    sel = 1'b1;
    txn(1'b1, 2'd2, 32'h8, 32'h13572468, rd, e, lat);
    total++; if (lat !== 1) $display("FAIL lat0_wr_lat: got %0d want 1", lat); else passed++;
    txn(1'b0, 2'd2, 32'h8, 32'h0, rd, e, lat);
    total++; if (lat !== 1) $display("FAIL lat0_rd_lat: got %0d want 1", lat); else passed++;
    total++; if (rd !== 32'h13572468) $display("FAIL lat0_rd: got %h want 13572468", rd); else passed++;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h8; wdata = 32'h0;
    @(posedge clk); #1;
    req = 1'b0; wr = 1'b0;
    reset = 1'b1;
    #1;
    total++; if (data_ok0 !== 1'b0) $display("FAIL lat0_abort_dok: got %b want 0", data_ok0); else passed++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (addr_ok0 !== 1'b1) $display("FAIL lat0_abort_aok: got %b want 1", addr_ok0); else passed++;
    txn(1'b0, 2'd2, 32'h8, 32'h0, rd, e, lat);
    total++; if (rd !== 32'h13572468) $display("FAIL lat0_abort_keep: got %h want 13572468", rd); else passed++;
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exp [3];
    logic ok_s, dk, want_ok, want_dk;
    int hs;
    addrs[0] = 32'h10; addrs[1] = 32'h0;        addrs[2] = 32'h20;
    exp[0]   = 32'h1234AAEF; exp[1] = 32'hCAFEF00D; exp[2] = 32'h0BADF00D;
    hs = 0;
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = addrs[0];
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      ok_s = addr_ok2;
      dk = data_ok2;
      want_ok = ((c % 4) == 0);
      want_dk = ((c % 4) == 3);
      total++; if (ok_s !== want_ok) $display("FAIL b2b_addr_ok c=%0d: got %b want %b", c, ok_s, want_ok); else passed++;
      total++; if (dk !== want_dk) $display("FAIL b2b_data_ok c=%0d: got %b want %b", c, dk, want_dk); else passed++;
      if (want_dk) begin
        total++; if (rdata2 !== exp[c/4]) $display("FAIL b2b_rdata c=%0d: got %h want %h", c, rdata2, exp[c/4]); else passed++;
      end
      @(posedge clk); #1;
      if (ok_s) begin
        hs++;
        if (hs < 3) addr = addrs[hs];
        else req = 1'b0;
      end
    end
    req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_half();
    test_misaligned();
    test_out_of_range();
    test_reset_abort();
    test_back_to_back();
    test_latency_zero();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_phys_responder.md
Name: sram_phys_responder

Overview:
- Responder end of the CPU data/instruction memory interface.
- Accepts requests that already carry translated physical addresses (kseg0/kseg1 folded to 0x0000_0000–0x1FFF_FFFF) and serves them from an internal word-organised RAM.
- Fixed, programmable response latency, one outstanding transaction at a time.
- Flags misaligned and out-of-range accesses instead of silently aliasing them.
- Sits behind the address translator, as the bench/FPGA stand-in for the memory side.

Parameters:
- MEM_AW, 10, word-address width; RAM holds 2^MEM_AW 32-bit words (default 4 KiB).
- LATENCY, 2, idle cycles between acceptance and the response cycle (legal range 0–15).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  initiator request valid
- wr  in  1  1 = write, 0 = read; sampled with req
- size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
- addr  in  32  physical byte address
- wdata  in  32  write data, byte lanes in place (lane = addr[1:0])
- addr_ok  out  1  request accepted this cycle when req & addr_ok
- data_ok  out  1  one-cycle response strobe
- rdata  out  32  read data, valid only while data_ok = 1
- err  out  1  error status of the current response, valid only while data_ok = 1

Behaviour:
- Reset (async, high):
  - state = IDLE; latency counter = 0; captured request cleared.
  - data_ok = 0, rdata = 0, err = 0; addr_ok = 1 once reset deasserts.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - addr_ok = (state == IDLE), combinational from state only, never from req.
  - Handshake = req & addr_ok at a rising edge. On handshake, register wr, size, addr and wdata.
  - IDLE → WAIT on handshake when LATENCY > 0, with the counter loaded with LATENCY. IDLE → RESP on handshake when LATENCY = 0.
  - WAIT decrements the counter each cycle and moves to RESP on the cycle it reaches 1→0.
  - RESP asserts data_ok = 1 for exactly one cycle, then returns to IDLE.
- Latency: data_ok is high in cycle N+LATENCY+1, where N is the handshake cycle. Maximum throughput is one transaction per LATENCY+2 cycles.
- Error check, evaluated on the captured request:
  - misaligned: size 1 with addr[0] = 1, size 2 with addr[1:0] ≠ 0, or size 3 is misaligned.
  - out of range: any of addr[31:MEM_AW+2] nonzero.
  - err = misaligned | out of range.
- On error:
  - no RAM write occurs.
  - rdata = 0 in the RESP cycle.
  - err = 1 in the RESP cycle.
- Write (no error): committed in the RESP cycle.
  - size 0 writes lane addr[1:0].
  - size 1 writes lanes {addr[1],0} and {addr[1],1}.
  - size 2 writes all four lanes.
  - Other lanes are unchanged. rdata = 0 during a write response.
- Read (no error):
  - rdata = the full word at addr[MEM_AW+1:2], registered in the RESP cycle. No lane shifting.
  - The read reflects every write whose RESP cycle has completed.
- req outside IDLE is ignored. Inputs need not be held after the handshake.
- Reset mid-transaction (WAIT or RESP):
  - aborts; no write is committed and data_ok does not pulse.
  - addr_ok is 1 in the first cycle after reset deasserts.
- Counter width is 4 bits, so LATENCY > 15 is illegal. Elaboration must fail via a generate-time check.

Test Plan:
- LATENCY=2, write word addr 0x0000_0010 wdata 0xDEADBEEF, then read 0x10 → each data_ok 3 cycles after its handshake; read rdata = 0xDEADBEEF, err = 0.
- Byte write addr 0x11, size 0, wdata 0x0000_AA00, then word read 0x10 → rdata = 0xDEADAAEF. Halfword write 0x12 wdata 0x1234_0000 → subsequent read = 0x1234AAEF.
- Misaligned accesses: halfword write addr 0x13, word read addr 0x12, size 3 read addr 0x10 → each response has err = 1 and rdata = 0; word 0x10 is still 0x1234AAEF.
- Out of range, MEM_AW=10: read addr 0x0000_1000 and write addr 0x1FC0_0000 → err = 1, rdata = 0; word 0 is unchanged.
- req held high with 3 distinct reads, LATENCY=2 → addr_ok pattern 1,0,0,0 repeating, handshakes every 4 cycles, data_ok at cycles 3, 7 and 11.
- Write to 0x20 issued, reset pulsed during WAIT → no data_ok; addr_ok = 1 right after release; reading 0x20 returns the pre-test contents. Repeat with LATENCY=0 and check data_ok in the cycle after the handshake.
